// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg: shared types and constants for the calculator display path.
//   state_t    : scan FSM states (SHOW = digit lit, GAP = all anodes off).
//   SEG_BLANK  : active-low segment pattern with every segment off.
//   SEG_MINUS  : active-low pattern lighting only segment g.
//   HEX_SEG    : active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
package calc_disp_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to 7-segment decoder.
//   nibble : input  [3:0]  hex digit to show.
//   seg    : output [6:0]  {g,f,e,d,c,b,a}, active-low.
module hex_to_seg7
    import calc_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/calc_disp.sv
// calc_disp: captures a 16-bit accumulator value and drives a 4-digit
// multiplexed common-anode 7-segment display with an all-off gap between
// digits, leading-zero blanking and an optional two's-complement sign.
//   clk         : input        system clock, rising edge.
//   resetn      : input        asynchronous active-low reset.
//   value       : input  [15:0] value to display.
//   load        : input        strobe; captures value and signed_mode.
//   signed_mode : input        1 = signed display, 0 = unsigned hex.
//   an          : output [3:0] digit anodes, active-low, an[0] rightmost.
//   seg         : output [6:0] {g,f,e,d,c,b,a}, active-low.
//   dp          : output       decimal point, active-low.
module calc_disp
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYC     = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        signed_mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYC) ? REFRESH_DIV : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    state_t        state_reg;
    logic [1:0]    idx_reg;
    logic [CW-1:0] cnt_reg;

    // Shadow takes every load; the display copy only changes at the frame
    // boundary so a single frame never mixes two values.
    logic [15:0]   shadow_val_reg;
    logic          shadow_sgn_reg;
    logic [15:0]   disp_val_reg;
    logic          disp_sgn_reg;

    logic          neg;
    logic [15:0]   mag;
    logic [1:0]    msn;
    logic [3:0]    nib [4];
    logic [6:0]    hex_seg;
    logic [6:0]    digit_seg;
    logic          digit_dp;

    // Sign/magnitude split. 0x8000 negates to itself, which still reads
    // correctly as an unsigned magnitude.
    assign neg = disp_sgn_reg & disp_val_reg[15];
    assign mag = neg ? (~disp_val_reg + 16'd1) : disp_val_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib
            assign nib[gi] = mag[4*gi +: 4];
        end
    endgenerate

    // Index of the most significant nonzero nibble (0 when the value is 0).
    always_comb begin
        msn = 2'd0;
        if (nib[3] != 4'd0)      msn = 2'd3;
        else if (nib[2] != 4'd0) msn = 2'd2;
        else if (nib[1] != 4'd0) msn = 2'd1;
    end

    hex_to_seg7 u_dec (
        .nibble (nib[idx_reg]),
        .seg    (hex_seg)
    );

    // Content of the currently scanned digit. The minus sign sits just left
    // of the top significant digit; with all four digits in use it has no
    // room, so the decimal point on digit 3 stands in for it.
    always_comb begin
        digit_seg = SEG_BLANK;
        digit_dp  = 1'b1;
        if (idx_reg <= msn) begin
            digit_seg = hex_seg;
        end else if (neg && ({1'b0, idx_reg} == ({1'b0, msn} + 3'd1))) begin
            digit_seg = SEG_MINUS;
        end
        if (neg && (msn == 2'd3) && (idx_reg == 2'd3)) begin
            digit_dp = 1'b0;
        end
    end

    // Scan FSM with registered outputs: the outputs reflect the state and
    // index held during the previous cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= SHOW;
            idx_reg        <= 2'd0;
            cnt_reg        <= '0;
            shadow_val_reg <= 16'd0;
            shadow_sgn_reg <= 1'b0;
            disp_val_reg   <= 16'd0;
            disp_sgn_reg   <= 1'b0;
            an             <= 4'b1111;
            seg            <= SEG_BLANK;
            dp             <= 1'b1;
        end else begin
            if (load) begin
                shadow_val_reg <= value;
                shadow_sgn_reg <= signed_mode;
            end

            case (state_reg)
                SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        state_reg <= GAP;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= SHOW;
                        idx_reg   <= idx_reg + 2'd1;
                        cnt_reg   <= '0;
                        // Frame boundary: uses the shadow contents from before
                        // any load arriving on this same edge.
                        if (idx_reg == 2'd3) begin
                            disp_val_reg <= shadow_val_reg;
                            disp_sgn_reg <= shadow_sgn_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= SHOW;
                    cnt_reg   <= '0;
                end
            endcase

            if (state_reg == SHOW) begin
                an  <= ~(4'b0001 << idx_reg);
                seg <= digit_seg;
                dp  <= digit_dp;
            end else begin
                an  <= 4'b1111;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_disp.sv
// tb_calc_disp: directed self-checking bench for calc_disp with
// REFRESH_DIV=4, GAP_CYC=1 (20-cycle frame). Frame position p=(k-1)%20,
// where k counts rising edges since reset release; digit d is lit for
// p=5d..5d+3 and the gap is p=5d+4.
module tb_calc_disp;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] value = 16'd0;
    logic        load = 1'b0;
    logic        signed_mode = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errors = 0;
    int checks = 0;
    int k = 0;

    calc_disp #(.REFRESH_DIV(4), .GAP_CYC(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .value       (value),
        .load        (load),
        .signed_mode (signed_mode),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    function automatic int pos();
        return (k - 1) % 20;
    endfunction

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic goto(input int p);
        for (int i = 0; i < 40 && pos() != p; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [3:0] ea,
                       input logic [6:0] es, input logic ed);
        checks++;
        assert ({an, seg, dp} === {ea, es, ed}) else begin
            errors++;
            $error("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   tag, an, seg, dp, ea, es, ed);
        end
    endtask

    // Load is sampled on the next rising edge.
    task automatic do_load(input logic [15:0] v, input logic s);
        value = v;
        signed_mode = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        $display("load value=%h signed=%b at p=%0d", v, s, pos());
    endtask

    // Advance to the start of the next frame and check all four digits
    // (first lit cycle of each) plus the gap after digit 0.
    task automatic frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3, input logic dp3);
        tick();
        goto(0);
        chk({tag, "_d0"}, 4'b1110, d0, 1'b1);
        goto(4);
        chk({tag, "_gap"}, 4'b1111, SX, 1'b1);
        goto(5);
        chk({tag, "_d1"}, 4'b1101, d1, 1'b1);
        goto(10);
        chk({tag, "_d2"}, 4'b1011, d2, 1'b1);
        goto(15);
        chk({tag, "_d3"}, 4'b0111, d3, dp3);
        $display("frame %s checked at k=%0d", tag, k);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold", 4'b1111, SX, 1'b1);
        resetn = 1'b1;
        k = 0;
        tick();
        chk("rel_d0_first", 4'b1110, S0, 1'b1);
        goto(3);
        chk("rel_d0_last", 4'b1110, S0, 1'b1);
        goto(4);
        chk("rel_gap", 4'b1111, SX, 1'b1);
        goto(5);
        chk("rel_d1_blank", 4'b1101, SX, 1'b1);

        // Main function under several values.
        do_load(16'h1234, 1'b0);
        frame("u1234", S4, S3, S2, S1, 1'b1);
        do_load(16'h0005, 1'b0);
        frame("u0005", S5, SX, SX, SX, 1'b1);
        do_load(16'hFFFB, 1'b0);
        frame("uFFFB", SB, SF, SF, SF, 1'b1);
        do_load(16'hFFFB, 1'b1);
        frame("sFFFB", S5, SM, SX, SX, 1'b1);
        do_load(16'h8000, 1'b1);
        frame("s8000", S0, S0, S0, S8, 1'b0);
        do_load(16'hF00D, 1'b1);
        frame("sF00D", S3, SF, SF, SM, 1'b1);

        // Mid-frame load must not tear the current frame.
        tick();
        goto(5);
        do_load(16'h00AA, 1'b0);
        goto(10);
        chk("tear_d2_old", 4'b1011, SF, 1'b1);
        goto(15);
        chk("tear_d3_old", 4'b0111, SM, 1'b1);
        frame("u00AA", SA, SA, SX, SX, 1'b1);

        // Load on the boundary edge: shows one frame late.
        goto(18);
        do_load(16'h0777, 1'b0);
        frame("bnd_old", SA, SA, SX, SX, 1'b1);
        frame("bnd_new", S7, S7, S7, SX, 1'b1);

        // Asynchronous reset mid-SHOW; shadow contents are lost.
        do_load(16'h1234, 1'b0);
        tick();
        goto(2);
        resetn = 1'b0;
        #1;
        chk("async_reset", 4'b1111, SX, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", 4'b1111, SX, 1'b1);
        resetn = 1'b1;
        k = 0;
        tick();
        chk("rerel_d0", 4'b1110, S0, 1'b1);
        frame("post_reset", S0, SX, SX, SX, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
